// File: rtl/marker_corner_tracker.sv
// marker_corner_tracker
//
// Classifies each incoming pixel as marker-coloured and tracks four extreme
// corners of the marker blob over a frame. At end of frame the corners and
// matched-pixel count are latched and held stable for the next frame.
//
// Corner rules (s = X+Y, d = X-Y):
//   top-left = min s, bottom-right = max s, top-right = max d, bottom-left = min d.
//   Comparisons are strict, so on ties the earliest pixel in raster order wins.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   pixel_valid                     qualifies VGA_X/VGA_Y/pix_*
//   VGA_X, VGA_Y [10:0]             pixel column / line
//   pix_R, pix_G, pix_B [7:0]       pixel colour
//   thr_R_min, thr_G_max, thr_B_max match thresholds
//   top_left_*, top_right_*, bot_left_*, bot_right_* [10:0]  latched corners
//   color_count [18:0]              matched pixels in last completed frame
//   locked                          last completed frame reached p_min_count
//   frame_done                      one-cycle pulse at each latch event
//
// Optional build macro CORNER_SMOOTH_EN: when defined, a valid latch while
// already locked averages old and new corner coordinates.

module marker_corner_tracker #(
  parameter int unsigned p_screen_width  = 640,
  parameter int unsigned p_screen_height = 480,
  parameter int unsigned p_min_count     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_valid,
  input  logic [10:0] VGA_X,
  input  logic [10:0] VGA_Y,
  input  logic [7:0]  pix_R,
  input  logic [7:0]  pix_G,
  input  logic [7:0]  pix_B,
  input  logic [7:0]  thr_R_min,
  input  logic [7:0]  thr_G_max,
  input  logic [7:0]  thr_B_max,
  output logic [10:0] top_left_x,
  output logic [10:0] top_left_y,
  output logic [10:0] top_right_x,
  output logic [10:0] top_right_y,
  output logic [10:0] bot_left_x,
  output logic [10:0] bot_left_y,
  output logic [10:0] bot_right_x,
  output logic [10:0] bot_right_y,
  output logic [18:0] color_count,
  output logic        locked,
  output logic        frame_done
);

  localparam logic [10:0] LastX    = 11'(p_screen_width - 1);
  localparam logic [10:0] LastY    = 11'(p_screen_height - 1);
  localparam logic [18:0] MinCount = 19'(p_min_count);
`ifdef CORNER_SMOOTH_EN
  localparam logic SmoothEn = 1'b1;
`else
  localparam logic SmoothEn = 1'b0;
`endif

  // Corner coordinate index: 0 tl_x, 1 tl_y, 2 tr_x, 3 tr_y, 4 bl_x, 5 bl_y, 6 br_x, 7 br_y.

  // ---------------- Stage 1: classify and register ----------------
  logic        match_c, eof_c;
  logic        s1_match_q, s1_eof_q;
  logic [10:0] s1_x_q, s1_y_q;

  assign match_c = pixel_valid && (pix_R >= thr_R_min) && (pix_G < thr_G_max) &&
                   (pix_B < thr_B_max);
  assign eof_c   = pixel_valid && (VGA_X == LastX) && (VGA_Y == LastY);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_match_q <= 1'b0;
      s1_eof_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      s1_match_q <= match_c;
      s1_eof_q   <= eof_c;
      s1_x_q     <= VGA_X;
      s1_y_q     <= VGA_Y;
    end
  end

  // ---------------- Stage 2: corner accumulators ----------------
  logic [11:0]        pix_sum;
  logic signed [11:0] pix_diff;

  assign pix_sum  = {1'b0, s1_x_q} + {1'b0, s1_y_q};
  assign pix_diff = $signed({1'b0, s1_x_q}) - $signed({1'b0, s1_y_q});

  logic               s2_eof_q;
  logic               acc_empty_q, acc_empty_d, base_empty;
  logic [18:0]        acc_count_q, acc_count_d, base_count;
  logic [7:0][10:0]   acc_xy_q, acc_xy_d;
  logic [11:0]        acc_tl_s_q, acc_tl_s_d, acc_br_s_q, acc_br_s_d;
  logic signed [11:0] acc_tr_d_q, acc_tr_d_d, acc_bl_d_q, acc_bl_d_d;

  always_comb begin
    // On the latch edge the accumulators restart, but a match arriving on that
    // same edge already belongs to the new frame.
    base_empty  = acc_empty_q | s2_eof_q;
    base_count  = s2_eof_q ? '0 : acc_count_q;
    acc_empty_d = base_empty;
    acc_count_d = base_count;
    acc_xy_d    = acc_xy_q;
    acc_tl_s_d  = acc_tl_s_q;
    acc_br_s_d  = acc_br_s_q;
    acc_tr_d_d  = acc_tr_d_q;
    acc_bl_d_d  = acc_bl_d_q;
    if (s1_match_q) begin
      acc_empty_d = 1'b0;
      if (base_count != '1) acc_count_d = base_count + 19'd1;
      if (base_empty || (pix_sum < acc_tl_s_q)) begin
        acc_tl_s_d  = pix_sum;
        acc_xy_d[0] = s1_x_q;
        acc_xy_d[1] = s1_y_q;
      end
      if (base_empty || (pix_diff > acc_tr_d_q)) begin
        acc_tr_d_d  = pix_diff;
        acc_xy_d[2] = s1_x_q;
        acc_xy_d[3] = s1_y_q;
      end
      if (base_empty || (pix_diff < acc_bl_d_q)) begin
        acc_bl_d_d  = pix_diff;
        acc_xy_d[4] = s1_x_q;
        acc_xy_d[5] = s1_y_q;
      end
      if (base_empty || (pix_sum > acc_br_s_q)) begin
        acc_br_s_d  = pix_sum;
        acc_xy_d[6] = s1_x_q;
        acc_xy_d[7] = s1_y_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_eof_q    <= 1'b0;
      acc_empty_q <= 1'b1;
      acc_count_q <= '0;
      acc_xy_q    <= '0;
      acc_tl_s_q  <= '0;
      acc_br_s_q  <= '0;
      acc_tr_d_q  <= '0;
      acc_bl_d_q  <= '0;
    end else begin
      s2_eof_q    <= s1_eof_q;
      acc_empty_q <= acc_empty_d;
      acc_count_q <= acc_count_d;
      acc_xy_q    <= acc_xy_d;
      acc_tl_s_q  <= acc_tl_s_d;
      acc_br_s_q  <= acc_br_s_d;
      acc_tr_d_q  <= acc_tr_d_d;
      acc_bl_d_q  <= acc_bl_d_d;
    end
  end

  // ---------------- Latch stage ----------------
  logic             armed_q, locked_q, frame_done_q;
  logic [18:0]      color_count_q;
  logic [7:0][10:0] corner_q, corner_d;
  logic             frame_valid;
  logic [11:0]      blend_sum;

  assign frame_valid = (acc_count_q >= MinCount);

  always_comb begin
    corner_d  = acc_xy_q;
    blend_sum = '0;
    for (int i = 0; i < 8; i++) begin
      blend_sum = {1'b0, corner_q[i]} + {1'b0, acc_xy_q[i]};
      if (SmoothEn && locked_q) corner_d[i] = blend_sum[11:1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q       <= 1'b0;
      locked_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      color_count_q <= '0;
      corner_q      <= '0;
    end else begin
      frame_done_q <= s2_eof_q;
      if (s2_eof_q) begin
        armed_q <= 1'b1;
        // The first frame after reset was only partially observed.
        if (armed_q) begin
          color_count_q <= acc_count_q;
          locked_q      <= frame_valid;
          if (frame_valid) corner_q <= corner_d;
        end
      end
    end
  end

  assign top_left_x  = corner_q[0];
  assign top_left_y  = corner_q[1];
  assign top_right_x = corner_q[2];
  assign top_right_y = corner_q[3];
  assign bot_left_x  = corner_q[4];
  assign bot_left_y  = corner_q[5];
  assign bot_right_x = corner_q[6];
  assign bot_right_y = corner_q[7];
  assign color_count = color_count_q;
  assign locked      = locked_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_marker_corner_tracker.sv
// Self-checking bench for marker_corner_tracker on a 16x12 screen.

module tb_marker_corner_tracker;

  localparam int W     = 16;
  localparam int H     = 12;
  localparam int MIN   = 4;
  localparam int THR_R = 128;
  localparam int THR_G = 64;
  localparam int THR_B = 64;
`ifdef CORNER_SMOOTH_EN
  localparam bit SMOOTH = 1'b1;
`else
  localparam bit SMOOTH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pixel_valid = 1'b0;
  logic [10:0] VGA_X = '0, VGA_Y = '0;
  logic [7:0]  pix_R = '0, pix_G = '0, pix_B = '0;
  logic [7:0]  thr_R_min = 8'(THR_R), thr_G_max = 8'(THR_G), thr_B_max = 8'(THR_B);
  logic [10:0] top_left_x, top_left_y, top_right_x, top_right_y;
  logic [10:0] bot_left_x, bot_left_y, bot_right_x, bot_right_y;
  logic [18:0] color_count;
  logic        locked, frame_done;

  marker_corner_tracker #(
    .p_screen_width (W),
    .p_screen_height(H),
    .p_min_count    (MIN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_valid(pixel_valid),
    .VGA_X      (VGA_X),
    .VGA_Y      (VGA_Y),
    .pix_R      (pix_R),
    .pix_G      (pix_G),
    .pix_B      (pix_B),
    .thr_R_min  (thr_R_min),
    .thr_G_max  (thr_G_max),
    .thr_B_max  (thr_B_max),
    .top_left_x (top_left_x),
    .top_left_y (top_left_y),
    .top_right_x(top_right_x),
    .top_right_y(top_right_y),
    .bot_left_x (bot_left_x),
    .bot_left_y (bot_left_y),
    .bot_right_x(bot_right_x),
    .bot_right_y(bot_right_y),
    .color_count(color_count),
    .locked     (locked),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] tlx, tly, trx, tr_y, blx, bly, brx, bry;
    logic [18:0] cnt;
    logic        lk;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   pulses = 0;
  int   exp_pulses = 0;
  exp_t exp_q[$];
  int   fx[$];
  int   fy[$];

  // Reference model state: outputs as they should be after the last latch.
  bit   m_armed = 1'b0;
  bit   m_locked = 1'b0;
  int   m_cnt = 0;
  int   m_c[8];

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Every frame_done pulse is matched against the oldest pending expectation.
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      exp_t e;
      pulses++;
      chk("pending_expectation", 19'(exp_q.size() > 0), 19'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("top_left_x", 19'(top_left_x), 19'(e.tlx));
        chk("top_left_y", 19'(top_left_y), 19'(e.tly));
        chk("top_right_x", 19'(top_right_x), 19'(e.trx));
        chk("top_right_y", 19'(top_right_y), 19'(e.tr_y));
        chk("bot_left_x", 19'(bot_left_x), 19'(e.blx));
        chk("bot_left_y", 19'(bot_left_y), 19'(e.bly));
        chk("bot_right_x", 19'(bot_right_x), 19'(e.brx));
        chk("bot_right_y", 19'(bot_right_y), 19'(e.bry));
        chk("color_count", color_count, e.cnt);
        chk("locked", 19'(locked), 19'(e.lk));
      end
    end
  end

  task automatic model_latch();
    exp_t e;
    int   nc[8];
    int   tls, brs, trd, bld, s, d;
    tls = 0; brs = 0; trd = 0; bld = 0;
    for (int k = 0; k < 8; k++) nc[k] = 0;
    exp_pulses++;
    if (!m_armed) begin
      m_armed = 1'b1;
    end else begin
      m_cnt = fx.size();
      for (int i = 0; i < fx.size(); i++) begin
        s = fx[i] + fy[i];
        d = fx[i] - fy[i];
        if (i == 0 || s < tls) begin tls = s; nc[0] = fx[i]; nc[1] = fy[i]; end
        if (i == 0 || d > trd) begin trd = d; nc[2] = fx[i]; nc[3] = fy[i]; end
        if (i == 0 || d < bld) begin bld = d; nc[4] = fx[i]; nc[5] = fy[i]; end
        if (i == 0 || s > brs) begin brs = s; nc[6] = fx[i]; nc[7] = fy[i]; end
      end
      if (m_cnt >= MIN) begin
        for (int k = 0; k < 8; k++) m_c[k] = (SMOOTH && m_locked) ? (m_c[k] + nc[k]) / 2 : nc[k];
        m_locked = 1'b1;
      end else begin
        m_locked = 1'b0;
      end
    end
    e.tlx = 11'(m_c[0]); e.tly  = 11'(m_c[1]);
    e.trx = 11'(m_c[2]); e.tr_y = 11'(m_c[3]);
    e.blx = 11'(m_c[4]); e.bly  = 11'(m_c[5]);
    e.brx = 11'(m_c[6]); e.bry  = 11'(m_c[7]);
    e.cnt = 19'(m_cnt);
    e.lk  = m_locked;
    exp_q.push_back(e);
    fx.delete();
    fy.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pixel_valid = 1'b0;
    @(negedge clk);
    chk("rst_top_left_x", 19'(top_left_x), 19'd0);
    chk("rst_top_left_y", 19'(top_left_y), 19'd0);
    chk("rst_top_right_x", 19'(top_right_x), 19'd0);
    chk("rst_top_right_y", 19'(top_right_y), 19'd0);
    chk("rst_bot_left_x", 19'(bot_left_x), 19'd0);
    chk("rst_bot_left_y", 19'(bot_left_y), 19'd0);
    chk("rst_bot_right_x", 19'(bot_right_x), 19'd0);
    chk("rst_bot_right_y", 19'(bot_right_y), 19'd0);
    chk("rst_color_count", color_count, 19'd0);
    chk("rst_locked", 19'(locked), 19'd0);
    chk("rst_frame_done", 19'(frame_done), 19'd0);
    reset = 1'b0;
    m_armed = 1'b0;
    m_locked = 1'b0;
    m_cnt = 0;
    for (int k = 0; k < 8; k++) m_c[k] = 0;
    fx.delete();
    fy.delete();
  endtask

  // Drives one cycle; colour is chosen to (not) match, with threshold edges mixed in.
  task automatic drive_pix(input bit v, input int x, input int y, input bit want);
    logic [7:0] r, g, b;
    if (want) begin
      r = ($urandom_range(0, 3) == 0) ? 8'(THR_R) : 8'($urandom_range(THR_R, 255));
      g = ($urandom_range(0, 3) == 0) ? 8'(THR_G - 1) : 8'($urandom_range(0, THR_G - 1));
      b = ($urandom_range(0, 3) == 0) ? 8'(THR_B - 1) : 8'($urandom_range(0, THR_B - 1));
    end else begin
      r = 8'($urandom_range(0, 255));
      g = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0: r = ($urandom_range(0, 3) == 0) ? 8'(THR_R - 1) : 8'($urandom_range(0, THR_R - 1));
        1: g = ($urandom_range(0, 3) == 0) ? 8'(THR_G) : 8'($urandom_range(THR_G, 255));
        default: b = ($urandom_range(0, 3) == 0) ? 8'(THR_B) : 8'($urandom_range(THR_B, 255));
      endcase
    end
    @(negedge clk);
    pixel_valid = v;
    VGA_X = 11'(x);
    VGA_Y = 11'(y);
    pix_R = r;
    pix_G = g;
    pix_B = b;
    if (v && int'(r) >= THR_R && int'(g) < THR_G && int'(b) < THR_B) begin
      fx.push_back(x);
      fy.push_back(y);
    end
  endtask

  // mode: 0 square (5..8,3..6), 1 diamond at (8,6) radius 4, 2 random density/8 with bubbles,
  // 3 three isolated matches, 4 red only on invalid cycles, 5 square (9..12,7..10).
  task automatic drive_frame(input int mode, input int abort_at, input int density);
    int  idx, dx, dy;
    bit  want;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        idx = y * W + x;
        if (idx == abort_at) begin
          do_reset();
          return;
        end
        if (mode == 4) drive_pix(1'b0, x, y, 1'b1);
        else if (mode == 2 && $urandom_range(0, 7) == 0)
          drive_pix(1'b0, $urandom_range(0, W - 1), $urandom_range(0, H - 1),
                    1'($urandom_range(0, 1)));
        dx = (x > 8) ? x - 8 : 8 - x;
        dy = (y > 6) ? y - 6 : 6 - y;
        case (mode)
          0:       want = (x >= 5 && x <= 8 && y >= 3 && y <= 6);
          1:       want = (dx + dy <= 4);
          2:       want = (int'($urandom_range(0, 7)) < density);
          3:       want = (idx % 67 == 5);
          5:       want = (x >= 9 && x <= 12 && y >= 7 && y <= 10);
          default: want = 1'b0;
        endcase
        drive_pix(1'b1, x, y, want);
      end
    end
    model_latch();
  endtask

  initial begin
    for (int k = 0; k < 8; k++) m_c[k] = 0;
    do_reset();
    drive_frame(0, -1, 0);  // partial frame after reset: only frame_done
    drive_frame(0, -1, 0);  // square locks
    drive_frame(5, -1, 0);  // square moves (smoothing path when enabled)
    drive_frame(3, -1, 0);  // too few matches
    drive_frame(1, -1, 0);  // diamond with corner ties
    drive_frame(0, -1, 0);
    drive_frame(0, 100, 0); // reset mid-frame
    drive_frame(0, -1, 0);  // ignored as the arming frame
    drive_frame(5, -1, 0);
    drive_frame(4, -1, 0);  // red only while invalid
    drive_frame(2, -1, 8);  // every pixel matches
    for (int n = 0; n < 6; n++) drive_frame(2, -1, $urandom_range(1, 7));
    drive_frame(2, -1, 0);
    repeat (8) drive_pix(1'b0, 0, 0, 1'b0);
    chk("expectations_drained", 19'(exp_q.size()), 19'd0);
    chk("frame_done_pulses", 19'(pulses), 19'(exp_pulses));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
